// File: rtl/ramarb_if.sv
// Command/response/RAM-port bundle between requesters, the ramarb block and its distributed RAM.
interface ramarb_if #(
  parameter int NR = 4,
  parameter int DW = 32,
  parameter int AW = 6
);
  logic              clear;
  logic              busy;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_din;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_dout;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [DW-1:0]     mem_dout;

  modport slave (
    input  clear, req_valid, req_we, req_addr, req_din, mem_dout,
    output busy, req_ready, rsp_valid, rsp_dout, mem_we, mem_addr, mem_din
  );

  modport master (
    output clear, req_valid, req_we, req_addr, req_din, mem_dout,
    input  busy, req_ready, rsp_valid, rsp_dout, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/ramarb.sv
// Round-robin sharing of one single-port distributed RAM among NR requesters,
// with a zero-fill sequencer since the RAM itself has no reset.
module ramarb #(
  parameter int NR   = 4,
  parameter int DW   = 32,
  parameter int AW   = 6,
  parameter bit INIT = 1'b1
)(
  input  logic     clk,
  input  logic     nreset,
  ramarb_if.slave  bus
);
  localparam int PW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic {S_CLEAR, S_RUN} state_e;
  localparam state_e S_RST = INIT ? S_CLEAR : S_RUN;

  state_e         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [NR-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_dout_q, rsp_dout_d;

  logic           arb_en;
  logic [NR-1:0]  gnt;
  logic [PW-1:0]  gidx;
  logic           any_gnt;
  logic           g_we;
  logic [AW-1:0]  g_addr;
  logic [DW-1:0]  g_din;
  logic [NR-1:0]  rd_acc;

  assign arb_en = (state_q == S_RUN) && !bus.clear;

  // Search from ptr upward (mod NR); first valid requester wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    gnt     = '0;
    gidx    = '0;
    any_gnt = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NR; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NR)) sum = sum - (PW+1)'(NR);
      idx = sum[PW-1:0];
      if (arb_en && !any_gnt && bus.req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = idx;
        any_gnt  = 1'b1;
      end
    end
  end

  always_comb begin
    g_we   = 1'b0;
    g_addr = '0;
    g_din  = '0;
    for (int k = 0; k < NR; k++) begin
      if (gnt[k]) begin
        g_we   = bus.req_we[k];
        g_addr = bus.req_addr[k*AW +: AW];
        g_din  = bus.req_din[k*DW +: DW];
      end
    end
  end

  assign rd_acc      = gnt & ~bus.req_we;
  assign rsp_valid_d = rd_acc;
  assign rsp_dout_d  = (|rd_acc) ? bus.mem_dout : rsp_dout_q;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dout_q  <= rsp_dout_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_RUN;
      end
      default: begin
        if (bus.clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (any_gnt) begin
          ptr_d = (gidx == PW'(NR-1)) ? '0 : gidx + 1'b1;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy      = 1'b0;
    bus.req_ready = '0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_din   = '0;
    case (state_q)
      S_CLEAR: begin
        bus.busy     = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = cnt_q;
      end
      default: begin
        bus.req_ready = gnt;
        bus.mem_we    = g_we;
        bus.mem_addr  = g_addr;
        bus.mem_din   = g_din;
      end
    endcase
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dout  = rsp_dout_q;
endmodule

// File: tb/tb_ramarb.sv
// Scenario tasks drive ramarb against RAM models; read responses are scored from a queue.
module tb_ramarb;
  localparam int NR = 4, DW = 32, AW = 6, DEPTH = 1 << AW;

  typedef struct packed {
    logic [NR-1:0] v;
    logic [DW-1:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic nreset, nreset1;
  always #5 clk = ~clk;

  ramarb_if #(.NR(NR), .DW(DW), .AW(AW)) b0 ();
  ramarb_if #(.NR(NR), .DW(DW), .AW(AW)) b1 ();

  ramarb #(.NR(NR), .DW(DW), .AW(AW), .INIT(1'b1)) dut  (.clk(clk), .nreset(nreset),  .bus(b0));
  ramarb #(.NR(NR), .DW(DW), .AW(AW), .INIT(1'b0)) dut0 (.clk(clk), .nreset(nreset1), .bus(b1));

  logic [DW-1:0] ram0 [DEPTH];
  logic [DW-1:0] ram1 [DEPTH];
  always @(posedge clk) if (b0.mem_we === 1'b1) ram0[b0.mem_addr] <= b0.mem_din;
  always @(posedge clk) if (b1.mem_we === 1'b1) ram1[b1.mem_addr] <= b1.mem_din;
  assign b0.mem_dout = ram0[b0.mem_addr];
  assign b1.mem_dout = ram1[b1.mem_addr];

  logic [DW-1:0] shadow [DEPTH];
  rsp_t exp_q[$];
  rsp_t mon_e;
  int errors = 0;
  int checks = 0;

  // Response scoreboard
  always @(negedge clk) begin
    if (nreset === 1'b1 && b0.rsp_valid !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got v=%b d=%h, none expected", b0.rsp_valid, b0.rsp_dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (b0.rsp_valid !== mon_e.v || b0.rsp_dout !== mon_e.d) begin
          errors++;
          $display("FAIL rsp_data: got v=%b d=%h want v=%b d=%h",
                   b0.rsp_valid, b0.rsp_dout, mon_e.v, mon_e.d);
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic idle_reqs();
    b0.req_valid = '0; b0.req_we = '0; b0.req_addr = '0; b0.req_din = '0; b0.clear = 1'b0;
  endtask

  task automatic set_req(input int r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    b0.req_valid[r]          = 1'b1;
    b0.req_we[r]             = we;
    b0.req_addr[r*AW +: AW]  = a;
    b0.req_din[r*DW +: DW]   = d;
  endtask

  // Model bookkeeping for a command the bench expects to be granted.
  task automatic accept(input int g);
    logic [AW-1:0] a;
    rsp_t e;
    a = b0.req_addr[g*AW +: AW];
    if (b0.req_we[g]) shadow[a] = b0.req_din[g*DW +: DW];
    else begin
      e.v = NR'(1) << g;
      e.d = shadow[a];
      exp_q.push_back(e);
    end
  endtask

  task automatic zero_shadow();
    foreach (shadow[i]) shadow[i] = '0;
  endtask

  task automatic check_drained(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending responses want 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int bad;
    nreset = 1'b0; nreset1 = 1'b0;
    idle_reqs();
    b1.req_valid = '0; b1.req_we = '0; b1.req_addr = '0; b1.req_din = '0; b1.clear = 1'b0;
    repeat (3) nxt();
    checks++; if (b0.busy !== 1'b1)     begin errors++; $display("FAIL reset_busy: got %b want 1", b0.busy); end
    checks++; if (b0.req_ready !== '0)  begin errors++; $display("FAIL reset_ready: got %b want 0", b0.req_ready); end
    checks++; if (b0.rsp_valid !== '0)  begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", b0.rsp_valid); end
    checks++; if (b0.rsp_dout !== '0)   begin errors++; $display("FAIL reset_rsp_dout: got %h want 0", b0.rsp_dout); end
    nreset = 1'b1; #1;
    bad = 0;
    for (int c = 0; c < DEPTH; c++) begin
      if (b0.busy !== 1'b1 || b0.mem_we !== 1'b1 || b0.mem_din !== '0 || b0.mem_addr !== AW'(c)) bad++;
      nxt();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL init_clear_seq: got %0d bad cycles want 0", bad); end
    checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL init_clear_len: busy got %b want 0 after 64", b0.busy); end
    zero_shadow();
    idle_reqs(); set_req(0, 1'b0, 6'd5, '0); #1;
    checks++; if (b0.req_ready !== 4'b0001) begin errors++; $display("FAIL first_read_ready: got %b want 0001", b0.req_ready); end
    accept(0);
    nxt(); idle_reqs(); nxt();
    check_drained("reset");
  endtask

  task automatic test_write_read();
    idle_reqs(); set_req(2, 1'b1, 6'h3F, 32'hDEADBEEF); #1;
    checks++; if (b0.req_ready !== 4'b0100) begin errors++; $display("FAIL wr_ready: got %b want 0100", b0.req_ready); end
    checks++;
    if (b0.mem_we !== 1'b1 || b0.mem_addr !== 6'h3F || b0.mem_din !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_mem: got we=%b a=%h d=%h want 1 3f deadbeef", b0.mem_we, b0.mem_addr, b0.mem_din);
    end
    accept(2);
    nxt(); idle_reqs(); set_req(2, 1'b0, 6'h3F, '0); #1;
    checks++;
    if (b0.req_ready !== 4'b0100 || b0.mem_we !== 1'b0) begin
      errors++; $display("FAIL rd_ready: got r=%b we=%b want 0100 0", b0.req_ready, b0.mem_we);
    end
    accept(2);
    nxt(); idle_reqs(); nxt();
    check_drained("write_read");
  endtask

  task automatic test_fairness();
    logic [NR-1:0] want;
    int bad;
    idle_reqs(); set_req(3, 1'b0, 6'h3F, '0); #1;
    checks++; if (b0.req_ready !== 4'b1000) begin errors++; $display("FAIL fair_pre_ready: got %b want 1000", b0.req_ready); end
    accept(3);
    nxt();
    for (int cyc = 0; cyc < 8; cyc++) begin
      idle_reqs();
      for (int r = 0; r < NR; r++) set_req(r, (r % 2) == 0, AW'(8 + r), DW'(cyc * 16 + r));
      #1;
      want = NR'(1) << (cyc % NR);
      checks++;
      if (b0.req_ready !== want) begin
        errors++; $display("FAIL fair_grant[%0d]: got %b want %b", cyc, b0.req_ready, want);
      end
      accept(cyc % NR);
      nxt();
    end
    bad = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      idle_reqs(); set_req(1, 1'b0, 6'd8, '0); #1;
      if (b0.req_ready !== 4'b0010) bad++;
      accept(1);
      nxt();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fair_solo: got %0d missed grants want 0", bad); end
    idle_reqs(); nxt();
    check_drained("fairness");
  endtask

  task automatic test_clear_collision();
    int n;
    idle_reqs(); set_req(0, 1'b1, 6'd7, 32'h1234_5678); #1;
    checks++; if (b0.req_ready !== 4'b0001) begin errors++; $display("FAIL col_wr_ready: got %b want 0001", b0.req_ready); end
    accept(0);
    nxt(); idle_reqs(); set_req(3, 1'b0, 6'd7, '0); #1;
    checks++; if (b0.req_ready !== 4'b1000) begin errors++; $display("FAIL col_rd_ready: got %b want 1000", b0.req_ready); end
    accept(3);
    nxt(); idle_reqs(); set_req(0, 1'b0, 6'd1, '0); set_req(3, 1'b0, 6'd2, '0); b0.clear = 1'b1; #1;
    checks++;
    if (b0.req_ready !== 4'b0000 || b0.mem_we !== 1'b0 || b0.busy !== 1'b0) begin
      errors++; $display("FAIL col_no_grant: got r=%b we=%b busy=%b want 0000 0 0", b0.req_ready, b0.mem_we, b0.busy);
    end
    nxt(); b0.clear = 1'b0; #1;
    checks++;
    if (b0.busy !== 1'b1 || b0.req_ready !== '0 || b0.mem_addr !== '0 || b0.mem_we !== 1'b1) begin
      errors++; $display("FAIL col_clear_start: got busy=%b r=%b a=%h we=%b want 1 0 0 1",
                         b0.busy, b0.req_ready, b0.mem_addr, b0.mem_we);
    end
    check_drained("col_rsp_in_clear");
    idle_reqs();
    n = 0;
    while (b0.busy === 1'b1 && n < 200) begin n++; nxt(); end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL col_clear_len: got %0d want %0d", n, DEPTH); end
    zero_shadow();
    set_req(0, 1'b0, 6'd7, '0); #1;
    checks++; if (b0.req_ready !== 4'b0001) begin errors++; $display("FAIL col_post_ready: got %b want 0001", b0.req_ready); end
    accept(0);
    nxt(); idle_reqs(); nxt();
    check_drained("clear_collision");
  endtask

  task automatic test_reset_mid_clear();
    int n, bad;
    idle_reqs(); set_req(1, 1'b1, 6'd1, 32'hA5A5_0001); #1; accept(1);
    nxt(); idle_reqs(); set_req(1, 1'b0, 6'd1, '0); #1;
    checks++; if (b0.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_pre_ready: got %b want 0010", b0.req_ready); end
    accept(1);
    nxt(); idle_reqs(); nxt();
    b0.clear = 1'b1; nxt(); b0.clear = 1'b0;
    repeat (20) nxt();
    checks++;
    if (b0.mem_addr !== 6'd20 || b0.busy !== 1'b1) begin
      errors++; $display("FAIL mid_at20: got a=%0d busy=%b want 20 1", b0.mem_addr, b0.busy);
    end
    nreset = 1'b0; #1;
    checks++;
    if (b0.busy !== 1'b1 || b0.mem_addr !== '0 || b0.rsp_valid !== '0 || b0.rsp_dout !== '0 || b0.req_ready !== '0) begin
      errors++; $display("FAIL mid_reset_vals: got busy=%b a=%h rv=%b rd=%h r=%b want 1 0 0 0 0",
                         b0.busy, b0.mem_addr, b0.rsp_valid, b0.rsp_dout, b0.req_ready);
    end
    nxt(); nxt(); nreset = 1'b1; #1;
    n = 0; bad = 0;
    while (b0.busy === 1'b1 && n < 200) begin
      if (b0.mem_addr !== AW'(n)) bad++;
      n++; nxt();
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL mid_restart_len: got %0d want %0d", n, DEPTH); end
    checks++; if (bad != 0)   begin errors++; $display("FAIL mid_restart_addr: got %0d bad want 0", bad); end
    zero_shadow();
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, AW'(r), '0);
    #1;
    checks++; if (b0.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_reset: got %b want 0001", b0.req_ready); end
    accept(0);
    nxt(); idle_reqs(); nxt();
    check_drained("reset_mid_clear");
  endtask

  task automatic test_init0();
    b1.req_valid = 4'b1111; b1.req_we = '0; b1.req_addr = '0; b1.req_din = '0; b1.clear = 1'b0;
    nreset1 = 1'b1; #1;
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL init0_busy: got %b want 0", b1.busy); end
    checks++; if (b1.req_ready !== 4'b0001) begin errors++; $display("FAIL init0_first: got %b want 0001", b1.req_ready); end
    nxt();
    checks++; if (b1.req_ready !== 4'b0010) begin errors++; $display("FAIL init0_second: got %b want 0010", b1.req_ready); end
    checks++; if (b1.rsp_valid !== 4'b0001) begin errors++; $display("FAIL init0_rsp: got %b want 0001", b1.rsp_valid); end
    b1.req_valid = '0;
    nxt();
  endtask

  initial begin
    nreset = 1'b0; nreset1 = 1'b0;
    test_reset();
    test_write_read();
    test_fairness();
    test_clear_collision();
    test_reset_mid_clear();
    test_init0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
